seq_mul_ctrl: RTL and testbench
===============================

SEQ_MUL_CTRL -- requirements
Module: seq_mul_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a multiply; sampled only when busy=0.
REQ-005 abort  input  1  cancel an operation in progress; sampled only in RUN.
REQ-006 multiplicand  input  32  operand A; captured on an accepted start.
REQ-007 multiplier  input  32  operand B; captured on an accepted start.
REQ-008 adder_a  output  32  operand A driven to the external shared 32-bit adder.
REQ-009 adder_b  output  32  operand B driven to the external shared 32-bit adder.
REQ-010 adder_sum  input  32  adder result; combinational (adder_a+adder_b) mod 2^32, with no carry-out.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 result  output  32  registered (A*B) mod 2^32; holds its value until the next completion.

Function
REQ-014 The block SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 at a clock edge SHALL:
- load mcand_reg=multiplicand, mplier_reg=multiplier, acc=0 and cnt=0;
- move the state to RUN.
REQ-016 In IDLE, start=0 SHALL keep the state in IDLE.
REQ-017 Combinationally, adder_a SHALL equal acc at all times.
REQ-018 adder_b SHALL equal mcand_reg when state=RUN and mplier_reg[0]=1, and SHALL be 0 otherwise.
REQ-019 At each RUN edge with abort=0, the block SHALL update acc<=adder_sum, mcand_reg<=mcand_reg<<1 (zero fill), mplier_reg<=mplier_reg>>1 (zero fill) and cnt<=cnt+1.
REQ-020 At that edge, the block SHALL go to DONE if (mplier_reg>>1)==0 or cnt==31, and SHALL otherwise stay in RUN.
REQ-021 Number of RUN cycles SHALL be k=max(1, index of highest set bit of multiplier + 1), range 1..32.
REQ-022 On the RUN->DONE edge, result SHALL load the final value of acc, i.e. the adder_sum of that edge.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the state to IDLE unconditionally.
REQ-024 Latency: start accepted at edge E0 -> done high during the cycle following edge E_k -> busy low after edge E_(k+1).
REQ-025 start SHALL be ignored while busy=1 (RUN or DONE); the captured operands SHALL remain unaffected.
REQ-026 abort=1 in RUN SHALL have the following effect at the next edge:
- the state goes to IDLE;
- result is unchanged;
- done is not pulsed;
- acc is not updated.
REQ-027 abort SHALL have priority over completion at the same edge.
REQ-028 abort SHALL be ignored in IDLE and DONE.
REQ-029 start and abort asserted together in IDLE SHALL be treated as start only.
REQ-030 The result SHALL be correct modulo 2^32 for all unsigned and two's-complement operands, since the low 32 product bits are sign-independent.

Reset
REQ-031 rst_n=0 SHALL set, immediately and independently of clk, state=IDLE, acc=0, mcand_reg=0, mplier_reg=0, cnt=0, result=0, busy=0 and done=0.
REQ-032 Reset asserted mid-RUN or in DONE SHALL abandon the operation, suppress the done pulse and clear result to 0.
REQ-033 After rst_n deasserts, the first edge SHALL behave as IDLE; a start present on that edge SHALL be accepted.

Verification
REQ-034 The bench SHALL cover, with a behavioural adder model connected to the adder ports:
- Multiplicand 7, multiplier 6 -> 3 RUN cycles, done on cycle 4 after start, result=42; adder_b sequence 0, 14, 28.
- 0xFFFFFFFF x 0xFFFFFFFF -> 32 RUN cycles, result=0x00000001, busy high for 33 cycles.
- 5 x 0 -> 1 RUN cycle, result=0, done pulse still produced; then 0x80000000 x 2 -> 2 RUN cycles, result=0 (wrap-around).
- Start 3 x 9 completing with result 27; start 0x1234 x 0x10; pulse start with new operands at RUN cycle 2 and abort at RUN cycle 3 -> ignored start, no done, result stays 27, busy low next cycle.
- rst_n low mid-RUN of 100 x 100 -> busy=0, done=0, result=0 asynchronously; start 100 x 100 held on the first edge after release -> result=10000 after 7 RUN cycles.
- Start held continuously -> back-to-back operations, each re-accepted on the first IDLE edge, with exactly one done per operation.

Source files
------------

// File: rtl/seq_mul_ctrl.sv
// Sequential shift-and-add 32x32 multiplier controller (low 32 product bits).
// Drives an external shared adder and returns the product one bit per RUN cycle.
module seq_mul_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] multiplicand_i,
    input  logic [31:0] multiplier_i,
    output logic [31:0] adder_a_o,
    output logic [31:0] adder_b_o,
    input  logic [31:0] adder_sum_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic [31:0] acc_q,    acc_d;
    logic [31:0] mcand_q,  mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [31:0] result_q, result_d;

    assign adder_a_o = acc_q;
    assign adder_b_o = (state_q == RUN && mplier_q[0]) ? mcand_q : 32'd0;
    assign busy_o    = (state_q == RUN) || (state_q == DONE);
    assign done_o    = (state_q == DONE);
    assign result_o  = result_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d  = multiplicand_i;
                    mplier_d = multiplier_i;
                    acc_d    = 32'd0;
                    cnt_d    = 5'd0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Abort wins over completion and leaves acc/result untouched.
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = adder_sum_i;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 5'd1;
                    if ((mplier_q >> 1) == 32'd0 || cnt_q == 5'd31) begin
                        state_d  = DONE;
                        result_d = adder_sum_i;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Directed bench for seq_mul_ctrl with a behavioural model of the shared adder.
module tb_seq_mul_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] adderA;
    logic [31:0] adderB;
    logic [31:0] adderSum;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    int doneCount = 0;
    logic [31:0] bLog[$];

    seq_mul_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .multiplicand_i (multiplicand),
        .multiplier_i   (multiplier),
        .adder_a_o      (adderA),
        .adder_b_o      (adderB),
        .adder_sum_i    (adderSum),
        .busy_o         (busy),
        .done_o         (done),
        .result_o       (result)
    );

    assign adderSum = adderA + adderB;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observers sampled on the inactive edge: done pulses and adder_b per RUN cycle.
    always @(negedge clk) begin
        if (done) doneCount++;
        if (busy && !done) bLog.push_back(adderB);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit hold);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Entered at the negedge of RUN cycle 1; done must appear in cycle k+1.
    task automatic waitDone(input string tag, input int expK, input logic [31:0] expRes);
        int  n;
        bit  seen;
        n    = 1;
        seen = 1'b0;
        while (!seen && n <= 40) begin
            if (done) seen = 1'b1;
            else begin
                n++;
                @(negedge clk);
            end
        end
        checkOutput({tag, "_seen"},   32'(seen), 32'd1);
        checkOutput({tag, "_cycles"}, 32'(n),    32'(expK + 1));
        checkOutput({tag, "_result"}, result,    expRes);
        @(negedge clk);
        checkOutput({tag, "_idleBusy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_idleDone"}, 32'(done), 32'd0);
    endtask

    initial begin
        int d0;
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        #12;
        checkOutput("rst_busy",   32'(busy), 32'd0);
        checkOutput("rst_done",   32'(done), 32'd0);
        checkOutput("rst_result", result,    32'd0);
        checkOutput("rst_adderA", adderA,    32'd0);
        checkOutput("rst_adderB", adderB,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 7 x 6: three RUN cycles with adder_b 0, 14, 28.
        bLog.delete();
        applyStimulus(32'd7, 32'd6, 1'b0);
        waitDone("m7x6", 3, 32'd42);
        checkOutput("m7x6_bLen", 32'(bLog.size()), 32'd3);
        if (bLog.size() == 3) begin
            checkOutput("m7x6_b0", bLog[0], 32'd0);
            checkOutput("m7x6_b1", bLog[1], 32'd14);
            checkOutput("m7x6_b2", bLog[2], 32'd28);
        end

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        waitDone("mFFxFF", 32, 32'h0000_0001);

        d0 = doneCount;
        applyStimulus(32'd5, 32'd0, 1'b0);
        waitDone("m5x0", 1, 32'd0);
        checkOutput("m5x0_donePulse", 32'(doneCount - d0), 32'd1);

        applyStimulus(32'h8000_0000, 32'd2, 1'b0);
        waitDone("mWrap", 2, 32'd0);

        // Start with abort in IDLE counts as a plain start.
        @(negedge clk);
        abort        = 1'b1;
        start        = 1'b1;
        multiplicand = 32'd3;
        multiplier   = 32'd9;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        waitDone("m3x9", 4, 32'd27);

        // Ignored start in RUN cycle 2, abort in RUN cycle 3.
        d0 = doneCount;
        applyStimulus(32'h1234, 32'h10, 1'b0);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 32'hFFFF;
        multiplier   = 32'hFFFF;
        @(negedge clk);
        start = 1'b0;
        checkOutput("abort_stillBusy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy",   32'(busy), 32'd0);
        checkOutput("abort_done",   32'(done), 32'd0);
        checkOutput("abort_result", result,    32'd27);
        checkOutput("abort_noDone", 32'(doneCount - d0), 32'd0);

        // Asynchronous reset mid-RUN, then start held across release.
        applyStimulus(32'd100, 32'd100, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_busy",   32'(busy), 32'd0);
        checkOutput("arst_done",   32'(done), 32'd0);
        checkOutput("arst_result", result,    32'd0);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 32'd100;
        multiplier   = 32'd100;
        rst_n        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("m100x100", 7, 32'd10000);

        // Start held: three back-to-back 3 x 5 operations.
        d0 = doneCount;
        applyStimulus(32'd3, 32'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            waitDone("b2b", 3, 32'd15);
            if (i < 2) @(negedge clk);
        end
        start = 1'b0;
        #1;
        checkOutput("b2b_doneCount", 32'(doneCount - d0), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
